// File: rtl/inst_fetch_align.sv
// Fetch/align stage: walks a word-addressed instruction memory by byte PC and emits one aligned
// RV32IC instruction (16- or 32-bit, including word-straddling ones) per beat to decode.
module inst_fetch_align #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                redirect_valid,
  input  logic [ADDR_W+1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [ADDR_W+1:0]   out_pc,
  output logic                out_is_compressed
);

  localparam int unsigned PcW = ADDR_W + 2;
  localparam logic [PcW-1:0] ResetPc = PcW'(RESET_PC) & ~PcW'(1);

  typedef enum logic [0:0] {StRun, StStraddle} state_e;

  state_e            state_q;
  logic [PcW-1:0]    pc_q;
  logic [15:0]       hold_half_q;
  logic [ADDR_W-1:0] pc_word;
  logic [15:0]       half;
  logic              advance;

  assign pc_word   = pc_q[PcW-1:2];
  // In STRADDLE the upper half of the instruction lives in the next word (wraps to word 0).
  assign imem_addr = (state_q == StStraddle) ? pc_word + ADDR_W'(1) : pc_word;
  assign half      = pc_q[1] ? imem_data[31:16] : imem_data[15:0];
  assign advance   = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q              <= ResetPc;
      state_q           <= StRun;
      hold_half_q       <= 16'h0000;
      out_valid         <= 1'b0;
      out_inst          <= 32'h0000_0000;
      out_pc            <= '0;
      out_is_compressed <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= {redirect_pc[PcW-1:1], 1'b0};
      state_q     <= StRun;
      hold_half_q <= 16'h0000;
      out_valid   <= 1'b0;
    end else if (advance) begin
      unique case (state_q)
        StRun: begin
          if (half[1:0] != 2'b11) begin
            out_valid         <= 1'b1;
            out_inst          <= {16'h0000, half};
            out_pc            <= pc_q;
            out_is_compressed <= 1'b1;
            pc_q              <= pc_q + PcW'(2);
          end else if (!pc_q[1]) begin
            out_valid         <= 1'b1;
            out_inst          <= imem_data;
            out_pc            <= pc_q;
            out_is_compressed <= 1'b0;
            pc_q              <= pc_q + PcW'(4);
          end else begin
            // Lower half of a 32-bit instruction sits in the top of this word; fetch next word.
            out_valid   <= 1'b0;
            hold_half_q <= half;
            state_q     <= StStraddle;
          end
        end
        StStraddle: begin
          out_valid         <= 1'b1;
          out_inst          <= {imem_data[15:0], hold_half_q};
          out_pc            <= pc_q;
          out_is_compressed <= 1'b0;
          pc_q              <= pc_q + PcW'(4);
          state_q           <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_align.sv
// Bench for inst_fetch_align: directed scenarios followed by a randomized run scored against a
// halfword-level model of the RV32IC instruction stream held in the memory array.
module tb_inst_fetch_align;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned PcW    = ADDR_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid = 1'b0;
  logic [PcW-1:0]    redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_inst;
  logic [PcW-1:0]    out_pc;
  logic              out_is_compressed;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int checks = 0;
  int failures = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  inst_fetch_align #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_inst          (out_inst),
    .out_pc            (out_pc),
    .out_is_compressed (out_is_compressed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0000_0013;
  endtask

  // Halfword at byte address p of the flat memory image.
  function automatic logic [15:0] half_at(input logic [PcW-1:0] p);
    logic [31:0] w;
    w = mem[p[PcW-1:2]];
    return p[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction starting at byte PC p: compressed if low bits != 11, else two consecutive halves.
  task automatic model_inst(input logic [PcW-1:0] p, output logic [31:0] inst,
                            output logic c, output logic [PcW-1:0] len);
    logic [15:0]    lo;
    logic [PcW-1:0] p2;
    lo = half_at(p);
    p2 = p + PcW'(2);
    if (lo[1:0] != 2'b11) begin
      inst = {16'h0000, lo};
      c    = 1'b1;
      len  = PcW'(2);
    end else begin
      inst = {half_at(p2), lo};
      c    = 1'b0;
      len  = PcW'(4);
    end
  endtask

  logic [31:0]    snap_inst;
  logic [PcW-1:0] snap_pc;
  logic           snap_c;
  logic [ADDR_W-1:0] snap_addr;
  logic           stall_pending;
  logic [PcW-1:0] model_pc;
  logic [31:0]    ei;
  logic           ec;
  logic [PcW-1:0] elen;
  int             handshakes;

  initial begin
    // 1: reset values, then back-to-back 32-bit instructions
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013 | (32'(i + 1) << 20);
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_c", 64'(out_is_compressed), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_pc", 64'(out_pc), 64'(4 * i));
      chk("t1_inst", 64'(out_inst), 64'(32'h0000_0013 | (32'(i + 1) << 20)));
      chk("t1_c", 64'(out_is_compressed), 64'd0);
    end

    // 2: two compressed halves then a 32-bit instruction
    clear_mem();
    mem[0] = 32'h0505_4081;
    do_reset();
    tick();
    chk("t2_pc0", 64'(out_pc), 64'd0);
    chk("t2_inst0", 64'(out_inst), 64'h0000_4081);
    chk("t2_c0", 64'(out_is_compressed), 64'd1);
    tick();
    chk("t2_pc2", 64'(out_pc), 64'd2);
    chk("t2_inst2", 64'(out_inst), 64'h0000_0505);
    chk("t2_c2", 64'(out_is_compressed), 64'd1);
    tick();
    chk("t2_pc4", 64'(out_pc), 64'd4);
    chk("t2_inst4", 64'(out_inst), 64'h0000_0013);
    chk("t2_c4", 64'(out_is_compressed), 64'd0);

    // 3: straddling 32-bit instruction costs one bubble
    clear_mem();
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h0000_0010;
    do_reset();
    tick();
    chk("t3_inst0", 64'(out_inst), 64'h0000_4501);
    chk("t3_c0", 64'(out_is_compressed), 64'd1);
    tick();
    chk("t3_bubble", 64'(out_valid), 64'd0);
    chk("t3_straddle_addr", 64'(imem_addr), 64'd1);
    tick();
    chk("t3_valid2", 64'(out_valid), 64'd1);
    chk("t3_pc2", 64'(out_pc), 64'd2);
    chk("t3_inst2", 64'(out_inst), 64'h0010_0093);
    chk("t3_c2", 64'(out_is_compressed), 64'd0);
    tick();
    chk("t3_pc6", 64'(out_pc), 64'd6);

    // 4: backpressure holds the slot and the fetch address
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 32'h0000_0013 | (32'(i + 1) << 20);
    do_reset();
    tick();
    tick();
    out_ready = 1'b0;
    snap_inst = out_inst;
    snap_pc = out_pc;
    snap_addr = imem_addr;
    chk("t4_pc_before", 64'(out_pc), 64'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_pc", 64'(out_pc), 64'(snap_pc));
      chk("t4_hold_inst", 64'(out_inst), 64'(snap_inst));
      chk("t4_hold_addr", 64'(imem_addr), 64'(snap_addr));
    end
    out_ready = 1'b1;
    tick();
    chk("t4_after_pc8", 64'(out_pc), 64'd8);
    tick();
    chk("t4_after_pc12", 64'(out_pc), 64'd12);

    // 5: redirect while a straddle is in progress
    clear_mem();
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h0000_0010;
    mem[4] = 32'h00A0_0093;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = PcW'(8'h10);
    tick();
    redirect_valid = 1'b0;
    chk("t5_redir_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t5_pc", 64'(out_pc), 64'h10);
    chk("t5_valid", 64'(out_valid), 64'd1);
    chk("t5_inst", 64'(out_inst), 64'h00A0_0093);

    // 6: straddle across the wrap from the last word to word 0
    clear_mem();
    mem[63] = 32'h0093_0013;
    mem[0]  = 32'h0001_0010;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = PcW'(8'hFE);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t6_bubble", 64'(out_valid), 64'd0);
    chk("t6_wrap_addr", 64'(imem_addr), 64'd0);
    tick();
    chk("t6_pc", 64'(out_pc), 64'hFE);
    chk("t6_inst", 64'(out_inst), 64'h0010_0093);
    tick();
    chk("t6_next_pc", 64'(out_pc), 64'h02);
    chk("t6_next_inst", 64'(out_inst), 64'h0000_0001);

    // Randomized run: random image, ready, redirects and occasional reset.
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 1) == 0) mem[i][1:0] = 2'b11;
      if ($urandom_range(0, 1) == 0) mem[i][17:16] = 2'b11;
    end
    do_reset();
    model_pc = '0;
    stall_pending = 1'b0;
    handshakes = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (stall_pending) begin
        chk("rnd_stall_valid", 64'(out_valid), 64'd1);
        chk("rnd_stall_pc", 64'(out_pc), 64'(snap_pc));
        chk("rnd_stall_inst", 64'(out_inst), 64'(snap_inst));
        chk("rnd_stall_c", 64'(out_is_compressed), 64'(snap_c));
      end
      rst = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc = PcW'($urandom);
      if (rst) begin
        model_pc = '0;
      end else begin
        if (out_valid && out_ready) begin
          model_inst(model_pc, ei, ec, elen);
          chk("rnd_pc", 64'(out_pc), 64'(model_pc));
          chk("rnd_inst", 64'(out_inst), 64'(ei));
          chk("rnd_c", 64'(out_is_compressed), 64'(ec));
          model_pc = model_pc + elen;
          handshakes++;
        end
        if (redirect_valid) model_pc = redirect_pc & ~PcW'(1);
      end
      stall_pending = !rst && !redirect_valid && out_valid && !out_ready;
      snap_pc = out_pc;
      snap_inst = out_inst;
      snap_c = out_is_compressed;
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    chk("rnd_progress", 64'(handshakes > 1500), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
